// File: rtl/rr_multi_grant_sched.sv
// Registered round-robin scheduler: hands up to REQS free issue slots to WIDTH requesters
// per cycle, starting the scan at a rotating pointer so no requester starves.
module rr_multi_grant_sched #(
    parameter int WIDTH = 16,
    parameter int REQS  = 3,
    parameter int PTRW  = $clog2(WIDTH)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    en,
    input  logic [WIDTH-1:0]        req,
    input  logic [REQS-1:0]         slot_free,
    output logic [WIDTH-1:0]        gnt,
    output logic [WIDTH*REQS-1:0]   gnt_bus,
    output logic [REQS-1:0]         gnt_valid,
    output logic [PTRW-1:0]         ptr
);

    logic [WIDTH-1:0]               rot_req;
    logic [WIDTH-1:0]               remain;
    logic [REQS-1:0][WIDTH-1:0]     rot_slice;
    logic [WIDTH*REQS-1:0]          bus_nxt;
    logic [WIDTH-1:0]               gnt_nxt;
    logic [REQS-1:0]                valid_nxt;
    logic [PTRW-1:0]                ptr_nxt;
    logic [PTRW-1:0]                last_pos;
    logic [PTRW-1:0]                ridx;
    logic                           any_gnt;
    logic                           found;
    int                             sum;

    always_comb begin
        rot_req   = '0;
        rot_slice = '0;
        bus_nxt   = '0;
        gnt_nxt   = '0;
        valid_nxt = '0;
        last_pos  = '0;
        any_gnt   = 1'b0;
        found     = 1'b0;
        sum       = 0;
        ridx      = '0;
        ptr_nxt   = ptr;

        // Rotated position j holds requester (ptr + j) mod WIDTH; wrap is explicit so
        // non-power-of-two widths rotate correctly.
        for (int j = 0; j < WIDTH; j++) begin
            sum = int'(ptr) + j;
            if (sum >= WIDTH)
                sum = sum - WIDTH;
            ridx = PTRW'(sum);
            rot_req[j] = req[ridx];
        end

        remain = rot_req;
        for (int s = 0; s < REQS; s++) begin
            found = 1'b0;
            if (slot_free[s]) begin
                for (int j = 0; j < WIDTH; j++) begin
                    if (!found && remain[j]) begin
                        found           = 1'b1;
                        remain[j]       = 1'b0;
                        rot_slice[s][j] = 1'b1;
                        valid_nxt[s]    = 1'b1;
                        last_pos        = PTRW'(j);
                        any_gnt         = 1'b1;
                    end
                end
            end
        end

        // Slots take winners in ascending rotated order, so last_pos is the last granted.
        for (int s = 0; s < REQS; s++) begin
            for (int j = 0; j < WIDTH; j++) begin
                sum = j - int'(ptr);
                if (sum < 0)
                    sum = sum + WIDTH;
                ridx = PTRW'(sum);
                bus_nxt[s*WIDTH + j] = rot_slice[s][ridx];
            end
            gnt_nxt = gnt_nxt | bus_nxt[s*WIDTH +: WIDTH];
        end

        sum = int'(ptr) + int'(last_pos) + 1;
        if (sum >= WIDTH)
            sum = sum - WIDTH;
        if (any_gnt)
            ptr_nxt = PTRW'(sum);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gnt       <= '0;
            gnt_bus   <= '0;
            gnt_valid <= '0;
            ptr       <= '0;
        end else if (en) begin
            gnt       <= gnt_nxt;
            gnt_bus   <= bus_nxt;
            gnt_valid <= valid_nxt;
            ptr       <= ptr_nxt;
        end else begin
            gnt       <= '0;
            gnt_bus   <= '0;
            gnt_valid <= '0;
        end
    end

endmodule

// File: tb/tb_rr_multi_grant_sched.sv
// Bench for rr_multi_grant_sched: directed test-plan steps followed by random traffic,
// all compared against a queue-based scan-order model.
module tb_rr_multi_grant_sched;

    localparam int W = 16;
    localparam int R = 3;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           en = 1'b0;
    logic [W-1:0]   req = '0;
    logic [R-1:0]   slot_free = '0;
    logic [W-1:0]   gnt;
    logic [W*R-1:0] gnt_bus;
    logic [R-1:0]   gnt_valid;
    logic [3:0]     ptr;

    int tests = 0;
    int fails = 0;

    int             m_ptr = 0;
    logic [W-1:0]   m_gnt = '0;
    logic [W*R-1:0] m_bus = '0;
    logic [R-1:0]   m_valid = '0;

    rr_multi_grant_sched #(.WIDTH(W), .REQS(R)) dut (
        .clock(clock), .reset(reset), .en(en), .req(req), .slot_free(slot_free),
        .gnt(gnt), .gnt_bus(gnt_bus), .gnt_valid(gnt_valid), .ptr(ptr)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Scan requesters from the pointer with wrap, queue them, deal them to free slots in order.
    task automatic model(input logic e, input logic [W-1:0] r, input logic [R-1:0] f);
        int q[$];
        int last;
        int i;
        m_gnt = '0;
        m_bus = '0;
        m_valid = '0;
        if (!e) return;
        for (int k = 0; k < W; k++) begin
            i = (m_ptr + k) % W;
            if (r[i]) q.push_back(i);
        end
        last = -1;
        for (int s = 0; s < R; s++) begin
            if (f[s] && q.size() > 0) begin
                i = q.pop_front();
                m_bus[s*W + i] = 1'b1;
                m_valid[s] = 1'b1;
                last = i;
            end
        end
        for (int s = 0; s < R; s++)
            m_gnt = m_gnt | m_bus[s*W +: W];
        if (last >= 0)
            m_ptr = (last + 1) % W;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_gnt"}, 64'(gnt), 64'(m_gnt));
        check({tag, "_bus"}, 64'(gnt_bus), 64'(m_bus));
        check({tag, "_valid"}, 64'(gnt_valid), 64'(m_valid));
        check({tag, "_ptr"}, 64'(ptr), 64'(m_ptr));
    endtask

    // Inputs are applied away from the rising edge; outputs sampled 1 time unit after it.
    task automatic step(input string tag, input logic e, input logic [W-1:0] r,
                        input logic [R-1:0] f);
        en = e;
        req = r;
        slot_free = f;
        @(posedge clock);
        #1;
        model(e, r, f);
        check_model(tag);
        check({tag, "_subset"}, 64'(gnt & ~r), 64'd0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        m_ptr = 0;
        m_gnt = '0;
        m_bus = '0;
        m_valid = '0;
        check_model(tag);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        #2 reset = 1'b0;
        #1;
        check("por_gnt", 64'(gnt), 64'd0);
        check("por_valid", 64'(gnt_valid), 64'd0);
        check("por_ptr", 64'(ptr), 64'd0);
        @(negedge clock);
        reset = 1'b1;

        // Basic rotation from ptr=0.
        step("rot1", 1'b1, 16'hFFFF, 3'b111);
        check("rot1_s0", 64'(gnt_bus[0 +: W]), 64'h0001);
        check("rot1_s1", 64'(gnt_bus[W +: W]), 64'h0002);
        check("rot1_s2", 64'(gnt_bus[2*W +: W]), 64'h0004);
        check("rot1_ptr_c", 64'(ptr), 64'd3);
        step("rot2", 1'b1, 16'hFFFF, 3'b111);
        check("rot2_gnt_c", 64'(gnt), 64'h0038);
        check("rot2_ptr_c", 64'(ptr), 64'd6);
        step("rot3", 1'b1, 16'hFFFF, 3'b111);
        step("rot4", 1'b1, 16'hFFFF, 3'b111);

        // Mid-operation reset, asserted between edges.
        do_reset("midrst");
        check("midrst_ptr_c", 64'(ptr), 64'd0);
        step("post_rst", 1'b1, 16'hFFFF, 3'b111);
        check("post_rst_gnt_c", 64'(gnt), 64'h0007);

        // Wrap-around: park the pointer at 14, then straddle the top of the vector.
        do_reset("rst_wrap");
        step("to14", 1'b1, 16'h2000, 3'b001);
        check("to14_ptr_c", 64'(ptr), 64'd14);
        step("wrap", 1'b1, 16'hC003, 3'b111);
        check("wrap_s0", 64'(gnt_bus[0 +: W]), 64'h4000);
        check("wrap_s1", 64'(gnt_bus[W +: W]), 64'h8000);
        check("wrap_s2", 64'(gnt_bus[2*W +: W]), 64'h0001);
        check("wrap_valid_c", 64'(gnt_valid), 64'b111);
        check("wrap_ptr_c", 64'(ptr), 64'd1);

        // Busy middle slot.
        do_reset("rst_part");
        step("part", 1'b1, 16'hFFFF, 3'b101);
        check("part_s0", 64'(gnt_bus[0 +: W]), 64'h0001);
        check("part_s1", 64'(gnt_bus[W +: W]), 64'h0000);
        check("part_s2", 64'(gnt_bus[2*W +: W]), 64'h0002);
        check("part_valid_c", 64'(gnt_valid), 64'b101);
        check("part_ptr_c", 64'(ptr), 64'd2);

        // Fairness between the two extreme requesters.
        do_reset("rst_fair");
        for (int n = 0; n < 4; n++) begin
            step("fair", 1'b1, 16'h8001, 3'b001);
            check("fair_gnt_c", 64'(gnt), (n % 2 == 0) ? 64'h0001 : 64'h8000);
            check("fair_ptr_c", 64'(ptr), (n % 2 == 0) ? 64'd1 : 64'd0);
        end

        // Idle and enable: pointer must hold and grants clear.
        step("warm", 1'b1, 16'hFFFF, 3'b111);
        step("en_off", 1'b0, 16'hFFFF, 3'b111);
        check("en_off_gnt_c", 64'(gnt), 64'd0);
        check("en_off_ptr_c", 64'(ptr), 64'd3);
        step("no_req", 1'b1, 16'h0000, 3'b111);
        check("no_req_valid_c", 64'(gnt_valid), 64'd0);
        check("no_req_ptr_c", 64'(ptr), 64'd3);
        step("no_slot", 1'b1, 16'hFFFF, 3'b000);
        check("no_slot_ptr_c", 64'(ptr), 64'd3);
        step("resume", 1'b1, 16'hFFFF, 3'b111);
        check("resume_gnt_c", 64'(gnt), 64'h0038);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(39) == 0)
                do_reset("rnd_rst");
            step("rnd", ($urandom_range(7) != 0), W'($urandom),
                 R'($urandom_range(7)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
